// File: rtl/ofs_plat_port_soft_reset_seq_if.sv
// Request/status bundle between port reset sources and the soft reset sequencer.
// master: request side; slave: sequencer.
`ifndef OFS_PLAT_PARAM_HOST_CHAN_NUM_PORTS
`define OFS_PLAT_PARAM_HOST_CHAN_NUM_PORTS 1
`endif

interface ofs_plat_port_soft_reset_seq_if #(
    parameter int NUM_PORTS = `OFS_PLAT_PARAM_HOST_CHAN_NUM_PORTS
);
    logic [NUM_PORTS-1:0] port_rst_req;
    logic [NUM_PORTS-1:0] port_idle;
    logic [NUM_PORTS-1:0] pClk_reset_n;
    logic [NUM_PORTS-1:0] port_in_reset;
    logic [NUM_PORTS-1:0] drain_timeout;

    modport master (
        output port_rst_req,
        output port_idle,
        input  pClk_reset_n,
        input  port_in_reset,
        input  drain_timeout
    );

    modport slave (
        input  port_rst_req,
        input  port_idle,
        output pClk_reset_n,
        output port_in_reset,
        output drain_timeout
    );
endinterface

// File: rtl/ofs_plat_port_soft_reset_seq.sv
// Per-port drain-aware soft reset sequencer (RUN -> DRAIN -> ASSERT -> RUN).
// OFS_PLAT_SOFT_RESET_DRAIN_TIMEOUT_EN adds a bounded DRAIN and a sticky timeout flag.
`ifndef OFS_PLAT_PARAM_HOST_CHAN_NUM_PORTS
`define OFS_PLAT_PARAM_HOST_CHAN_NUM_PORTS 1
`endif

module ofs_plat_port_soft_reset_seq #(
    parameter int NUM_PORTS            = `OFS_PLAT_PARAM_HOST_CHAN_NUM_PORTS,
    parameter int MIN_RESET_CYCLES     = 16,
    parameter int DRAIN_TIMEOUT_CYCLES = 4096
) (
    input  logic pClk,
    input  logic pClk_reset,
    ofs_plat_port_soft_reset_seq_if.slave rstIf
);

    localparam int CNT_MAX = (MIN_RESET_CYCLES > DRAIN_TIMEOUT_CYCLES) ?
                             MIN_RESET_CYCLES : DRAIN_TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_SAT = CW'(MIN_RESET_CYCLES);
    // Exit is taken on the edge that completes the last low cycle
    localparam logic [CW-1:0] MIN_M1  = CW'(MIN_RESET_CYCLES - 1);
`ifdef OFS_PLAT_SOFT_RESET_DRAIN_TIMEOUT_EN
    localparam logic [CW-1:0] DT_M1   = CW'(DRAIN_TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        state_e        state;
        logic [CW-1:0] cnt;
        logic          rstN;
        logic          inRst;
        logic          req;
        logic          idle;

`ifdef SYNTHESIS
        assign req  = rstIf.port_rst_req[p];
        assign idle = rstIf.port_idle[p];
`else
        // Unknown request forces reset; unknown idle never releases DRAIN
        assign req  = (rstIf.port_rst_req[p] !== 1'b0);
        assign idle = (rstIf.port_idle[p] === 1'b1);
`endif

`ifdef OFS_PLAT_SOFT_RESET_DRAIN_TIMEOUT_EN
        logic tmo;
`endif

        always_ff @(posedge pClk) begin
            if (pClk_reset) begin
                state <= ST_ASSERT;
                cnt   <= '0;
                rstN  <= 1'b0;
                inRst <= 1'b1;
`ifdef OFS_PLAT_SOFT_RESET_DRAIN_TIMEOUT_EN
                tmo   <= 1'b0;
`endif
            end else begin
                unique case (state)
                    ST_ASSERT: begin
                        if (cnt != CNT_SAT)
                            cnt <= cnt + CW'(1);
                        if (cnt >= MIN_M1 && !req) begin
                            state <= ST_RUN;
                            rstN  <= 1'b1;
                            inRst <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (req) begin
                            state <= ST_DRAIN;
                            cnt   <= '0;
                            inRst <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (idle) begin
                            state <= ST_ASSERT;
                            cnt   <= '0;
                            rstN  <= 1'b0;
                        end
`ifdef OFS_PLAT_SOFT_RESET_DRAIN_TIMEOUT_EN
                        else if (cnt == DT_M1) begin
                            state <= ST_ASSERT;
                            cnt   <= '0;
                            rstN  <= 1'b0;
                            tmo   <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
`endif
                    end
                    default: begin
                        state <= ST_ASSERT;
                        cnt   <= '0;
                        rstN  <= 1'b0;
                        inRst <= 1'b1;
                    end
                endcase
            end
        end

        assign rstIf.pClk_reset_n[p]  = rstN;
        assign rstIf.port_in_reset[p] = inRst;
`ifdef OFS_PLAT_SOFT_RESET_DRAIN_TIMEOUT_EN
        assign rstIf.drain_timeout[p] = tmo;
`else
        assign rstIf.drain_timeout[p] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ofs_plat_port_soft_reset_seq.sv
// Bench for the per-port soft reset sequencer: directed timing cases plus
// random traffic compared every cycle against a cycle-counting reference model.
`timescale 1ns/1ps

module tb_ofs_plat_port_soft_reset_seq;

    localparam int NP   = 2;
    localparam int MINC = 16;
    localparam int DTC  = 64;
`ifdef OFS_PLAT_SOFT_RESET_DRAIN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_LOW   = 2;

    logic pClk = 1'b0;
    logic pClk_reset = 1'b1;

    ofs_plat_port_soft_reset_seq_if #(.NUM_PORTS(NP)) rstIf();

    ofs_plat_port_soft_reset_seq #(
        .NUM_PORTS(NP),
        .MIN_RESET_CYCLES(MINC),
        .DRAIN_TIMEOUT_CYCLES(DTC)
    ) dut (
        .pClk(pClk),
        .pClk_reset(pClk_reset),
        .rstIf(rstIf.slave)
    );

    always #5 pClk = ~pClk;

    int nChk = 0;
    int nPass = 0;

    // Reference: what each port is doing and for how long it has done it
    int mMode[NP];
    int mHeld[NP];
    int mWait[NP];
    bit mFlag[NP];

    task automatic chk(input string tag, input int got, input int exp);
        nChk++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        logic r;
        logic [NP-1:0] q;
        logic [NP-1:0] i;
        r = pClk_reset;
        q = rstIf.port_rst_req;
        i = rstIf.port_idle;
        @(posedge pClk);
        for (int p = 0; p < NP; p++) begin
            if (r) begin
                mMode[p] = M_LOW;
                mHeld[p] = 0;
                mFlag[p] = 1'b0;
            end else if (mMode[p] == M_LOW) begin
                mHeld[p]++;
                if (mHeld[p] >= MINC && q[p] !== 1'b1) mMode[p] = M_RUN;
            end else if (mMode[p] == M_RUN) begin
                if (q[p] === 1'b1) begin
                    mMode[p] = M_DRAIN;
                    mWait[p] = 0;
                end
            end else begin
                if (i[p] === 1'b1) begin
                    mMode[p] = M_LOW;
                    mHeld[p] = 0;
                end else if (TMO_EN) begin
                    mWait[p]++;
                    if (mWait[p] == DTC) begin
                        mMode[p] = M_LOW;
                        mHeld[p] = 0;
                        mFlag[p] = 1'b1;
                    end
                end
            end
        end
        #1;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rstn%0d", p), int'(rstIf.pClk_reset_n[p]),
                int'(mMode[p] != M_LOW));
            chk($sformatf("inrst%0d", p), int'(rstIf.port_in_reset[p]),
                int'(mMode[p] != M_RUN));
            chk($sformatf("tmo%0d", p), int'(rstIf.drain_timeout[p]),
                int'(mFlag[p]));
        end
    endtask

    // Raise a request on port p; drop it after `hold` samples, raise idle
    // after `idleRise` samples (0 = leave idle as is). Report when reset_n
    // fell (in samples after the request) and how many samples it stayed low.
    task automatic measure(input int p, input int hold, input int idleRise,
                           output int lat, output int wid);
        int k;
        lat = -1;
        wid = 0;
        k = 0;
        rstIf.port_rst_req[p] = 1'b1;
        if (idleRise > 0) rstIf.port_idle[p] = 1'b0;
        while (k < 400) begin
            step();
            k++;
            if (k == hold) rstIf.port_rst_req[p] = 1'b0;
            if (k == idleRise) rstIf.port_idle[p] = 1'b1;
            if (lat < 0 && rstIf.pClk_reset_n[p] == 1'b0) lat = k;
            if (lat >= 0) begin
                if (rstIf.pClk_reset_n[p] == 1'b0) wid++;
                else break;
            end
        end
        chk("measure_bound", int'(k < 400), 1);
    endtask

    initial begin
        int lat;
        int wid;
        int lowAt;
        for (int p = 0; p < NP; p++) begin
            mMode[p] = M_LOW;
            mHeld[p] = 0;
            mWait[p] = 0;
            mFlag[p] = 1'b0;
        end
        rstIf.port_rst_req = '0;
        rstIf.port_idle = '1;

        // Power-up
        repeat (5) step();
        pClk_reset = 1'b0;
        repeat (MINC - 1) step();
        chk("pwr_still_low", int'(rstIf.pClk_reset_n), 0);
        step();
        chk("pwr_released", int'(rstIf.pClk_reset_n), 3);
        chk("pwr_inreset", int'(rstIf.port_in_reset), 0);
        repeat (3) step();

        // Short request on port 1
        measure(1, 1, 0, lat, wid);
        chk("short_lat", lat, 2);
        chk("short_wid", wid, MINC);
        chk("short_p0", int'(rstIf.pClk_reset_n[0]), 1);
        repeat (3) step();

        // Long request on port 0: low until one sample after it drops
        measure(0, 40, 0, lat, wid);
        chk("long_lat", lat, 2);
        chk("long_wid", wid, 39);
        chk("long_min", int'(wid >= MINC), 1);
        repeat (3) step();

        // Drain wait: request drops at 5, idle rises at 30
        measure(0, 5, 30, lat, wid);
        chk("drain_lat", lat, 31);
        chk("drain_wid", wid, MINC);
        repeat (3) step();

        // Drain timeout on port 1
        lowAt = -1;
        rstIf.port_idle[1] = 1'b0;
        rstIf.port_rst_req[1] = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 1) rstIf.port_rst_req[1] = 1'b0;
            if (lowAt < 0 && rstIf.pClk_reset_n[1] == 1'b0) lowAt = k;
        end
        chk("tmo_lat", lowAt, TMO_EN ? DTC + 1 : -1);
        chk("tmo_flag", int'(rstIf.drain_timeout[1]), int'(TMO_EN));
        rstIf.port_idle[1] = 1'b1;
        repeat (40) step();
        chk("tmo_sticky", int'(rstIf.drain_timeout[1]), int'(TMO_EN));
        chk("tmo_run", int'(rstIf.pClk_reset_n), 3);

        // Reset while port 0 drains and port 1 is mid-assert
        rstIf.port_idle[0] = 1'b0;
        rstIf.port_rst_req = 2'b11;
        step();
        rstIf.port_rst_req = 2'b00;
        repeat (8) step();
        pClk_reset = 1'b1;
        step();
        pClk_reset = 1'b0;
        chk("mid_flag_clr", int'(rstIf.drain_timeout), 0);
        chk("mid_both_low", int'(rstIf.pClk_reset_n), 0);
        repeat (MINC - 1) step();
        chk("mid_still_low", int'(rstIf.pClk_reset_n), 0);
        step();
        chk("mid_released", int'(rstIf.pClk_reset_n), 3);
        rstIf.port_idle[0] = 1'b1;
        repeat (3) step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(9) == 0)
                    rstIf.port_rst_req[p] = ~rstIf.port_rst_req[p];
                rstIf.port_idle[p] = ($urandom_range(3) != 0);
                if ($urandom_range(99) == 0) rstIf.port_idle[p] = 1'b0;
            end
            pClk_reset = ($urandom_range(399) == 0);
            step();
        end

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
